// File: rtl/ppa_pkg.sv
// Shared types and elaboration helpers for the pipelined Sklansky prefix adder.
package ppa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Bit n set means WIDTH = 2**n is a supported operand width (8, 16, 32, 64).
  localparam logic [6:0] LEGAL_WIDTH_LOG2_MASK = 7'b1111000;

  function automatic int levels_from_width(input int width);
    return $clog2(width);
  endfunction

  function automatic bit width_is_legal(input int width);
    int lv;
    lv = $clog2(width);
    if (width <= 0 || lv > 6 || (1 << lv) != width) return 1'b0;
    return LEGAL_WIDTH_LOG2_MASK[lv[2:0]];
  endfunction

endpackage

// File: rtl/ppa_prefix_stage.sv
// One combinational Sklansky prefix level over generate/propagate pairs.
module ppa_prefix_stage
  import ppa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> (LEVEL - 1)) & 1) == 1) begin : g_comb
      // Partner is the top bit of the block just below this bit's 2**(LEVEL-1) block.
      localparam int J = ((i >> (LEVEL - 1)) << (LEVEL - 1)) - 1;
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
      assign p_out[i] = p_in[i] & p_in[J];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ppa_pipe_adder.sv
// Pipelined Sklansky adder/subtractor: one register stage for bit terms, one per prefix level.
// Handshake: a side transfers on a rising edge with valid&ready; every stage advances together on en.
module ppa_pipe_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = levels_from_width(WIDTH);

  if (!width_is_legal(WIDTH)) begin : g_illegal_width
    $error("ppa_pipe_adder: WIDTH must be 8, 16, 32 or 64");
  end

  // Stage s (0..LEVELS-1) holds group terms after s prefix levels.
  logic [LEVELS-1:0][WIDTH-1:0] grp_g_q, grp_g_d;
  logic [LEVELS-1:0][WIDTH-1:0] grp_p_q, grp_p_d;
  logic [LEVELS-1:0][WIDTH-1:0] bit_p_q, bit_p_d;
  logic [LEVELS-1:0]            c_eff_q, c_eff_d;
  logic [LEVELS-1:0]            stage_v_q, stage_v_d;
  logic [WIDTH-1:0]             b_eff_q, b_eff_d;
  op_t                          op_q, op_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [LEVELS-1:0][WIDTH-1:0] lvl_g, lvl_p;
  logic [WIDTH-1:0]             carry_vec;
  logic                         en;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ppa_prefix_stage #(
      .WIDTH(WIDTH),
      .LEVEL(k)
    ) u_level (
      .g_in (grp_g_q[k-1]),
      .p_in (grp_p_q[k-1]),
      .g_out(lvl_g[k-1]),
      .p_out(lvl_p[k-1])
    );
  end

  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  // carry_vec[i] is the carry into bit i; bit 0 takes the effective carry-in.
  assign carry_vec = {lvl_g[LEVELS-1][WIDTH-2:0], c_eff_q[LEVELS-1]};

  always_comb begin
    grp_g_d     = grp_g_q;
    grp_p_d     = grp_p_q;
    bit_p_d     = bit_p_q;
    c_eff_d     = c_eff_q;
    stage_v_d   = stage_v_q;
    b_eff_d     = b_eff_q;
    op_d        = op_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (en) begin
      op_d          = op;
      b_eff_d       = (op == OP_SUB) ? ~b : b;
      c_eff_d[0]    = (op == OP_SUB) ? 1'b1 : cin;
      bit_p_d[0]    = a ^ b_eff_d;
      grp_p_d[0]    = a ^ b_eff_d;
      grp_g_d[0]    = a & b_eff_d;
      grp_g_d[0][0] = grp_g_d[0][0] | (bit_p_d[0][0] & c_eff_d[0]);
      stage_v_d[0]  = in_valid;
      for (int s = 1; s < LEVELS; s++) begin
        grp_g_d[s]   = lvl_g[s-1];
        grp_p_d[s]   = lvl_p[s-1];
        bit_p_d[s]   = bit_p_q[s-1];
        c_eff_d[s]   = c_eff_q[s-1];
        stage_v_d[s] = stage_v_q[s-1];
      end
      sum_d       = bit_p_q[LEVELS-1] ^ carry_vec;
      cout_d      = lvl_g[LEVELS-1][WIDTH-1];
      ovf_d       = lvl_g[LEVELS-1][WIDTH-2] ^ lvl_g[LEVELS-1][WIDTH-1];
      zero_d      = (sum_d == '0);
      out_valid_d = stage_v_q[LEVELS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_g_q     <= '0;
      grp_p_q     <= '0;
      bit_p_q     <= '0;
      c_eff_q     <= '0;
      stage_v_q   <= '0;
      b_eff_q     <= '0;
      op_q        <= OP_ADD;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      grp_g_q     <= grp_g_d;
      grp_p_q     <= grp_p_d;
      bit_p_q     <= bit_p_d;
      c_eff_q     <= c_eff_d;
      stage_v_q   <= stage_v_d;
      b_eff_q     <= b_eff_d;
      op_q        <= op_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Stage-0 operand copies and the last level's group propagate have no downstream reader.
  logic unused_bits;
  assign unused_bits = ^{lvl_p[LEVELS-1], b_eff_q, op_q};

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_ppa_pipe_adder.sv
// Directed bench for ppa_pipe_adder: WIDTH=16 main instance plus 8/32/64 width instances.
module tb_ppa_pipe_adder;
  import ppa_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;
  op_t          op;

  logic         n8_in_valid, n8_in_ready, n8_cin, n8_out_valid, n8_out_ready, n8_cout, n8_ovf, n8_zero;
  logic [7:0]   n8_a, n8_b, n8_sum;
  logic         n32_in_valid, n32_in_ready, n32_cin, n32_out_valid, n32_out_ready, n32_cout, n32_ovf, n32_zero;
  logic [31:0]  n32_a, n32_b, n32_sum;
  logic         n64_in_valid, n64_in_ready, n64_cin, n64_out_valid, n64_out_ready, n64_cout, n64_ovf, n64_zero;
  logic [63:0]  n64_a, n64_b, n64_sum;
  op_t          nw_op;

  ppa_pipe_adder #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );
  ppa_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(n8_in_valid), .in_ready(n8_in_ready), .a(n8_a), .b(n8_b),
    .cin(n8_cin), .op(nw_op), .out_valid(n8_out_valid), .out_ready(n8_out_ready), .sum(n8_sum),
    .cout(n8_cout), .ovf(n8_ovf), .zero(n8_zero)
  );
  ppa_pipe_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(n32_in_valid), .in_ready(n32_in_ready), .a(n32_a), .b(n32_b),
    .cin(n32_cin), .op(nw_op), .out_valid(n32_out_valid), .out_ready(n32_out_ready), .sum(n32_sum),
    .cout(n32_cout), .ovf(n32_ovf), .zero(n32_zero)
  );
  ppa_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(n64_in_valid), .in_ready(n64_in_ready), .a(n64_a), .b(n64_b),
    .cin(n64_cin), .op(nw_op), .out_valid(n64_out_valid), .out_ready(n64_out_ready), .sum(n64_sum),
    .cout(n64_cout), .ovf(n64_ovf), .zero(n64_zero)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard entries are {zero, ovf, cout, sum}.
  logic [W+2:0] exp_q[$];
  logic [W-1:0] sa[16];
  logic [W-1:0] sb[16];
  logic         sc[16];
  op_t          so[16];

  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input op_t o);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         c;
    logic         v;
    yy   = (o == OP_SUB) ? ~y : y;
    c    = (o == OP_SUB) ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
    v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {full[W-1:0] == '0, v, full[W], full[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait for its result; lat counts edges from acceptance inclusive.
  task automatic run_single(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                            input op_t xo, output logic [W+2:0] res, output int lat);
    a = xa; b = xb; cin = xc; op = xo; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res = {zero, ovf, cout, sum};
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({out_valid, sum, cout, ovf, zero} !== '0)
      $display("FAIL reset_outputs: got %b_%h_%b%b%b expected all zero", out_valid, sum, cout, ovf, zero);
    else pass_cnt++;
    total_cnt++;
    if ({n8_out_valid, n32_out_valid, n64_out_valid} !== 3'b000)
      $display("FAIL reset_width_valid: got %b expected 000", {n8_out_valid, n32_out_valid, n64_out_valid});
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add_wrap();
    logic [W+2:0] res;
    int lat;
    run_single(16'hFFFF, 16'h0001, 1'b0, OP_ADD, res, lat);
    total_cnt++;
    if (lat !== 5) $display("FAIL add_wrap_latency: got %0d expected 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== {1'b1, 1'b0, 1'b1, 16'h0000})
      $display("FAIL add_wrap_result: got %h expected %h", res, {1'b1, 1'b0, 1'b1, 16'h0000});
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL add_wrap_no_dup: got out_valid=%b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5] = '{16'h8000, 16'h0003, 16'h0005, 16'h7FFF, 16'h1234};
    logic [W-1:0] vb[5] = '{16'h0001, 16'h0005, 16'h0005, 16'h0000, 16'h4321};
    logic         vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op_t          vo[5] = '{OP_SUB, OP_SUB, OP_SUB, OP_ADD, OP_ADD};
    // {zero, ovf, cout, sum}, worked out by hand.
    logic [W+2:0] ve[5] = '{{3'b011, 16'h7FFF}, {3'b000, 16'hFFFE}, {3'b101, 16'h0000},
                            {3'b010, 16'h8000}, {3'b000, 16'h5556}};
    logic [W+2:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_single(va[i], vb[i], vc[i], vo[i], res, lat);
      total_cnt++;
      if (res !== ve[i] || lat !== 5)
        $display("FAIL directed_%0d: got %h lat %0d expected %h lat 5", i, res, lat, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, takes = 0, first = -1, last = -1, not_ready = 0;
    logic [W+2:0] exp;
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom_range(0, 65535));
      sb[i] = 16'($urandom_range(0, 65535));
      sc[i] = ($urandom_range(0, 1) == 1);
      so[i] = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
    end
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && takes < 8; cyc++) begin
      in_valid = (sent < 8);
      if (sent < 8) begin a = sa[sent]; b = sb[sent]; cin = sc[sent]; op = so[sent]; end
      #1;
      if (in_valid && !in_ready) not_ready++;
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if ({zero, ovf, cout, sum} !== exp)
          $display("FAIL b2b_result_%0d: got %h expected %h", takes, {zero, ovf, cout, sum}, exp);
        else pass_cnt++;
        if (first < 0) first = cyc;
        last = cyc;
        takes++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, op));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (takes !== 8 || last - first !== 7)
      $display("FAIL b2b_consecutive: got %0d results over %0d cycles expected 8 over 8", takes, last - first + 1);
    else pass_cnt++;
    total_cnt++;
    if (not_ready !== 0) $display("FAIL b2b_in_ready: got %0d stalled inputs expected 0", not_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int sent = 0, takes = 0, stall_seen = 0;
    logic held_valid = 1'b0;
    logic [W+2:0] held, exp;
    for (int i = 0; i < 10; i++) begin
      sa[i] = 16'h1111 * 16'(i + 1);
      sb[i] = 16'h0F0F + 16'(i);
      sc[i] = i[0];
      so[i] = i[1] ? OP_SUB : OP_ADD;
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && takes < 10; cyc++) begin
      out_ready = !(cyc >= 7 && cyc < 11);
      in_valid  = (sent < 10);
      if (sent < 10) begin a = sa[sent]; b = sb[sent]; cin = sc[sent]; op = so[sent]; end
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_cyc%0d: got %b expected 0", cyc, in_ready);
        else pass_cnt++;
        if (held_valid) begin
          total_cnt++;
          if ({zero, ovf, cout, sum} !== held)
            $display("FAIL bp_stable_cyc%0d: got %h expected %h", cyc, {zero, ovf, cout, sum}, held);
          else pass_cnt++;
        end
        held = {zero, ovf, cout, sum};
        held_valid = 1'b1;
      end else held_valid = 1'b0;
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if ({zero, ovf, cout, sum} !== exp)
          $display("FAIL bp_result_%0d: got %h expected %h", takes, {zero, ovf, cout, sum}, exp);
        else pass_cnt++;
        takes++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, op));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (takes !== 10 || exp_q.size() !== 0)
      $display("FAIL bp_count: got %0d results, %0d pending expected 10, 0", takes, exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (stall_seen !== 4) $display("FAIL bp_stall_cycles: got %0d expected 4", stall_seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_flight();
    int stale = 0;
    logic [W+2:0] res;
    int lat;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; op = OP_ADD; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0101 * 16'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    total_cnt++;
    if ({out_valid, sum, cout, ovf, zero} !== '0)
      $display("FAIL flight_reset_outputs: got %b_%h_%b%b%b expected all zero", out_valid, sum, cout, ovf, zero);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flight_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) stale++;
    end
    total_cnt++;
    if (stale !== 0) $display("FAIL flight_stale: got %0d valid cycles expected 0", stale);
    else pass_cnt++;
    run_single(16'h0001, 16'h0002, 1'b0, OP_ADD, res, lat);
    total_cnt++;
    if (res !== {3'b000, 16'h0003} || lat !== 5)
      $display("FAIL flight_recover: got %h lat %0d expected %h lat 5", res, lat, {3'b000, 16'h0003});
    else pass_cnt++;
  endtask

  task automatic test_widths();
    int lat8 = 0, lat32 = 0, lat64 = 0;
    logic [10:0] r8;
    logic [34:0] r32;
    logic [66:0] r64;
    n8_a = '1;  n8_b = '0;  n8_cin = 1'b1;
    n32_a = '1; n32_b = '0; n32_cin = 1'b1;
    n64_a = '1; n64_b = '0; n64_cin = 1'b1;
    nw_op = OP_ADD;
    n8_in_valid = 1'b1; n32_in_valid = 1'b1; n64_in_valid = 1'b1;
    tick();
    n8_in_valid = 1'b0; n32_in_valid = 1'b0; n64_in_valid = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) tick();
      if (n8_out_valid === 1'b1 && lat8 == 0) begin lat8 = e; r8 = {n8_sum, n8_cout, n8_ovf, n8_zero}; end
      if (n32_out_valid === 1'b1 && lat32 == 0) begin lat32 = e; r32 = {n32_sum, n32_cout, n32_ovf, n32_zero}; end
      if (n64_out_valid === 1'b1 && lat64 == 0) begin lat64 = e; r64 = {n64_sum, n64_cout, n64_ovf, n64_zero}; end
    end
    total_cnt++;
    if (lat8 !== 4 || r8 !== {8'h00, 3'b101})
      $display("FAIL width8: got %h lat %0d expected %h lat 4", r8, lat8, {8'h00, 3'b101});
    else pass_cnt++;
    total_cnt++;
    if (lat32 !== 6 || r32 !== {32'h0, 3'b101})
      $display("FAIL width32: got %h lat %0d expected %h lat 6", r32, lat32, {32'h0, 3'b101});
    else pass_cnt++;
    total_cnt++;
    if (lat64 !== 7 || r64 !== {64'h0, 3'b101})
      $display("FAIL width64: got %h lat %0d expected %h lat 7", r64, lat64, {64'h0, 3'b101});
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    n8_in_valid = 1'b0; n8_a = '0; n8_b = '0; n8_cin = 1'b0; n8_out_ready = 1'b1;
    n32_in_valid = 1'b0; n32_a = '0; n32_b = '0; n32_cin = 1'b0; n32_out_ready = 1'b1;
    n64_in_valid = 1'b0; n64_a = '0; n64_b = '0; n64_cin = 1'b0; n64_out_ready = 1'b1;
    nw_op = OP_ADD;
    test_reset();
    test_add_wrap();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_in_flight();
    test_widths();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
